spi_master_param: RTL and testbench
===================================

Name: spi_master_param

Overview:
- Parametrised SPI master, successor to the fixed 16-bit mode-0 master.
- Configurable frame width, SCLK divider, and front/back porch lengths.
- SPI mode (CPOL/CPHA) is selectable per transfer.
- Sits between on-chip command logic and off-chip SPI peripherals: one frame per wrt pulse, done pulse and rd_data when the frame completes.

Parameters:
- DATA_W, 16: frame width in bits (>=2).
- SCLK_DIV_LOG2, 5: SCLK period = 2^SCLK_DIV_LOG2 clk cycles; half period H = 2^(SCLK_DIV_LOG2-1) (>=1).
- FRONT_PORCH, 2: clk cycles SS_n is low before the first SCLK edge (>=1).
- BACK_PORCH, 8: clk cycles SS_n is held low after the last SCLK edge (>=1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- wrt  in  1  start-transfer strobe, single cycle.
- cmd  in  DATA_W  transmit word, MSB first, latched on accepted wrt.
- mode  in  2  {CPOL,CPHA}, latched on accepted wrt.
- MISO  in  1  serial data from slave.
- SCLK  out  1  serial clock, registered.
- SS_n  out  1  active-low slave select, registered.
- MOSI  out  1  serial data to slave = MSB of tx shift register.
- busy  out  1  high from the cycle after an accepted wrt until done.
- done  out  1  one-cycle pulse at frame completion.
- rd_data  out  DATA_W  received word, updated in the done cycle.

Behaviour:
- Reset (async, immediate, including mid-transfer):
  - state=IDLE, SS_n=1, SCLK=0, latched mode=00, tx shift=0 (MOSI=0), busy=0, done=0, rd_data=all ones, all counters=0.
- States: IDLE -> FRONT -> XFER -> BACK -> IDLE.
- IDLE:
  - SS_n=1, SCLK=latched CPOL.
  - wrt accepted here only, including the done cycle, which allows back-to-back frames.
  - Accepted wrt: latch cmd into tx shift, latch mode; next cycle SS_n=0, busy=1, state=FRONT.
  - wrt is ignored in every other state; cmd/mode changes while busy have no effect.
- FRONT:
  - Lasts FRONT_PORCH cycles; SCLK=CPOL; MOSI=cmd MSB.
- XFER:
  - Lasts 2*DATA_W*H cycles.
  - SCLK toggles on the clk edge ending each H-cycle half period. Edges are numbered e=1..2*DATA_W; odd e are leading edges.
  - CPHA=0: sample MISO at odd e; shift tx left (0 in) at even e < 2*DATA_W.
  - CPHA=1: sample MISO at even e; shift tx at odd e >= 3.
  - Sampling shifts MISO into the rx register LSB, on the same clk edge that toggles SCLK.
  - After e=2*DATA_W, SCLK equals CPOL.
- BACK:
  - Lasts BACK_PORCH cycles; SS_n=0; SCLK=CPOL.
  - Then return to IDLE: SS_n=1, busy=0, done=1 for one cycle, rd_data=rx register in that same cycle.
- Latency:
  - done is high exactly 1+FRONT_PORCH+2*DATA_W*H+BACK_PORCH cycles after the wrt cycle.
  - With defaults this is 523 cycles.
- SS_n is high for at least 1 cycle between frames (the done cycle).
- Counters wrap only under control of the state machine; no free-running SCLK. SCLK never glitches while SS_n=1.
- Mode change between frames: SCLK moves to the new CPOL in the cycle after the accepted wrt, while SS_n is already low but before the first edge. The FRONT_PORCH>=1 requirement guarantees this.

Test Plan:
- Mode 00, MISO tied to MOSI (loopback), cmd=16'hA5C3 -> rd_data=16'hA5C3; done at cycle 523 after wrt; exactly 16 rising SCLK edges; SCLK idles 0.
- Mode 11, slave model returning 16'h3C5A (drives on leading edge, samples MOSI on trailing edge), cmd=16'h1234 -> rd_data=16'h3C5A; slave received 16'h1234; SCLK idles 1 before and after the frame.
- Modes 01 and 10 with the same slave model adjusted per mode -> rd_data=16'h3C5A, slave captures cmd exactly; no MOSI change within 1 cycle of a sampling edge.
- wrt re-pulsed with cmd=16'hFFFF at cycle 100 of a 16'h0001 frame -> ignored: slave receives 16'h0001, one done pulse only.
- rst_n low at cycle 200 of a frame -> same cycle: SS_n=1, SCLK=0, busy=0, rd_data=16'hFFFF; next wrt after reset completes normally.
- DATA_W=8, SCLK_DIV_LOG2=2, FRONT_PORCH=1, BACK_PORCH=1: wrt in the done cycle of the previous frame -> SS_n high exactly 1 cycle; each done 35 cycles after its wrt; loopback of 8'h96 then 8'h69 correct.

Source files
------------

// File: rtl/spi_master_param_if.sv
// rtl/spi_master_param_if.sv - command-side and SPI pin bundle for spi_master_param
// master modport is the SPI master's view; slave modport is the command logic / pin model view.
interface spi_master_param_if #(
  parameter int DATA_W = 16
);
  logic              wrt;
  logic [DATA_W-1:0] cmd;
  logic [1:0]        mode;
  logic              MISO;
  logic              SCLK;
  logic              SS_n;
  logic              MOSI;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rd_data;

  modport master (
    input  wrt, cmd, mode, MISO,
    output SCLK, SS_n, MOSI, busy, done, rd_data
  );

  modport slave (
    output wrt, cmd, mode, MISO,
    input  SCLK, SS_n, MOSI, busy, done, rd_data
  );
endinterface

// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parametrised SPI master, per-frame CPOL/CPHA, configurable porches
// One frame per accepted wrt: IDLE -> FRONT -> XFER -> BACK -> IDLE, done pulses on return to IDLE.
module spi_master_param #(
  parameter int DATA_W        = 16,
  parameter int SCLK_DIV_LOG2 = 5,
  parameter int FRONT_PORCH   = 2,
  parameter int BACK_PORCH    = 8
) (
  input logic              clk,
  input logic              rst_n,
  spi_master_param_if.master bus
);

  localparam int H         = 1 << (SCLK_DIV_LOG2 - 1);
  localparam int PORCH_MAX = (FRONT_PORCH > BACK_PORCH) ? FRONT_PORCH : BACK_PORCH;
  localparam int PCNT_W    = $clog2(PORCH_MAX + 1);
  localparam int HCNT_W    = (SCLK_DIV_LOG2 > 1) ? SCLK_DIV_LOG2 - 1 : 1;
  localparam int ECNT_W    = $clog2(2 * DATA_W + 1);

  localparam logic [PCNT_W-1:0] FP_LAST = PCNT_W'(FRONT_PORCH - 1);
  localparam logic [PCNT_W-1:0] BP_LAST = PCNT_W'(BACK_PORCH - 1);
  localparam logic [HCNT_W-1:0] H_LAST  = HCNT_W'(H - 1);
  localparam logic [ECNT_W-1:0] E_LAST  = ECNT_W'(2 * DATA_W - 1);
  localparam logic [ECNT_W-1:0] E_TWO   = ECNT_W'(2);

  generate
    if (DATA_W < 2)        begin : g_bad_data_w  $error("DATA_W must be >= 2");        end
    if (SCLK_DIV_LOG2 < 1) begin : g_bad_div     $error("SCLK_DIV_LOG2 must be >= 1"); end
    if (FRONT_PORCH < 1)   begin : g_bad_front   $error("FRONT_PORCH must be >= 1");   end
    if (BACK_PORCH < 1)    begin : g_bad_back    $error("BACK_PORCH must be >= 1");    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_FRONT,
    S_XFER,
    S_BACK
  } state_t;

  state_t              state_q, state_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic [ECNT_W-1:0]   ecnt_q, ecnt_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   rd_q, rd_d;
  logic                sclk_q, sclk_d;
  logic                ss_n_q, ss_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // ecnt_q counts edges already made, so the pending edge is odd (leading) when ecnt_q is even
  logic leading;
  logic do_sample;
  logic do_shift;

  always_comb begin
    leading   = ~ecnt_q[0];
    do_sample = 1'b0;
    do_shift  = 1'b0;
    if (mode_q[0]) begin
      do_sample = ~leading;
      do_shift  = leading && (ecnt_q >= E_TWO);
    end else begin
      do_sample = leading;
      do_shift  = ~leading && (ecnt_q != E_LAST);
    end
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    hcnt_d  = hcnt_q;
    ecnt_d  = ecnt_q;
    mode_d  = mode_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    sclk_d  = sclk_q;
    ss_n_d  = ss_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        ss_n_d = 1'b1;
        busy_d = 1'b0;
        sclk_d = mode_q[1];
        if (bus.wrt) begin
          tx_d    = bus.cmd;
          mode_d  = bus.mode;
          // new CPOL appears together with SS_n low, ahead of any edge
          sclk_d  = bus.mode[1];
          ss_n_d  = 1'b0;
          busy_d  = 1'b1;
          pcnt_d  = '0;
          state_d = S_FRONT;
        end
      end

      S_FRONT: begin
        if (pcnt_q == FP_LAST) begin
          pcnt_d  = '0;
          hcnt_d  = '0;
          ecnt_d  = '0;
          state_d = S_XFER;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end

      S_XFER: begin
        if (hcnt_q == H_LAST) begin
          hcnt_d = '0;
          sclk_d = ~sclk_q;
          ecnt_d = ecnt_q + 1'b1;
          if (do_sample) begin
            rx_d = {rx_q[DATA_W-2:0], bus.MISO};
          end
          if (do_shift) begin
            tx_d = {tx_q[DATA_W-2:0], 1'b0};
          end
          if (ecnt_q == E_LAST) begin
            ecnt_d  = '0;
            pcnt_d  = '0;
            state_d = S_BACK;
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end

      S_BACK: begin
        if (pcnt_q == BP_LAST) begin
          pcnt_d  = '0;
          ss_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rd_d    = rx_q;
          state_d = S_IDLE;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pcnt_q  <= '0;
      hcnt_q  <= '0;
      ecnt_q  <= '0;
      mode_q  <= 2'b00;
      tx_q    <= '0;
      rx_q    <= '0;
      rd_q    <= '1;
      sclk_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      hcnt_q  <= hcnt_d;
      ecnt_q  <= ecnt_d;
      mode_q  <= mode_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
      sclk_q  <= sclk_d;
      ss_n_q  <= ss_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.SCLK    = sclk_q;
  assign bus.SS_n    = ss_n_q;
  assign bus.MOSI    = tx_q[DATA_W-1];
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_data = rd_q;

endmodule

// File: tb/tb_spi_master_param.sv
// tb/tb_spi_master_param.sv - self-checking bench for spi_master_param
// Frame timing model per DUT (16-bit defaults and an 8-bit fast variant) plus directed scenarios.
module tb_spi_master_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  spi_master_param_if #(.DATA_W(16)) ifa ();
  spi_master_param_if #(.DATA_W(8))  ifb ();

  spi_master_param #(.DATA_W(16), .SCLK_DIV_LOG2(5), .FRONT_PORCH(2), .BACK_PORCH(8)) dut_a (
    .clk(clk), .rst_n(rst_a), .bus(ifa)
  );
  spi_master_param #(.DATA_W(8), .SCLK_DIV_LOG2(2), .FRONT_PORCH(1), .BACK_PORCH(1)) dut_b (
    .clk(clk), .rst_n(rst_b), .bus(ifb)
  );

  // slave model on DUT A: returns slv_word, captures MOSI into slv_rx
  logic        lb_a     = 1'b1;
  logic [15:0] slv_word = 16'h3C5A;
  logic [15:0] slv_rx   = 16'h0000;
  logic        slv_miso = 1'b0;
  logic        slv_cpol = 1'b0;
  logic        slv_cpha = 1'b0;
  int          slv_n    = 0;
  int          slv_idx  = 0;

  assign ifa.MISO = lb_a ? ifa.MOSI : slv_miso;
  assign ifb.MISO = ifb.MOSI;

  always @(negedge ifa.SS_n) begin
    slv_rx = 16'h0000;
    if (!slv_cpha) begin
      slv_miso = slv_word[15];
      slv_idx  = 14;
    end else begin
      slv_idx = 15;
    end
  end

  always @(posedge ifa.SS_n) slv_n = 0;

  always @(ifa.SCLK) begin
    if (!ifa.SS_n && !(slv_n == 0 && ifa.SCLK == slv_cpol)) begin
      slv_n++;
      if ((ifa.SCLK != slv_cpol) != slv_cpha) begin
        slv_rx = {slv_rx[14:0], ifa.MOSI};
      end else if (slv_idx >= 0) begin
        slv_miso = slv_word[slv_idx];
        slv_idx--;
      end
    end
  end

  int rises_a = 0;
  int ndone_a = 0;
  always @(posedge ifa.SCLK) if (!ifa.SS_n) rises_a++;
  always @(negedge clk) if (ifa.done) ndone_a++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // frame model: per DUT geometry and the frame in flight
  int          m_dw[2] = '{16, 8};
  int          m_h[2]  = '{16, 2};
  int          m_fp[2] = '{2, 1};
  int          m_bp[2] = '{8, 1};
  logic        m_act[2];
  int          m_k[2];
  logic [31:0] m_cmd[2];
  logic [1:0]  m_mode[2];
  logic [31:0] m_rx[2];
  logic [31:0] m_rd[2];

  function automatic int edges_done(input int d, input int k);
    int x;
    x = k - 1 - m_fp[d];
    if (x < 0) return 0;
    if (x >= 2 * m_dw[d] * m_h[d]) return 2 * m_dw[d];
    return x / m_h[d];
  endfunction

  function automatic logic exp_mosi(input int d, input int k);
    int ed;
    int sh;
    ed = edges_done(d, k);
    if (m_mode[d][0]) sh = (ed >= 3) ? (ed - 1) / 2 : 0;
    else              sh = (ed / 2 > m_dw[d] - 1) ? m_dw[d] - 1 : ed / 2;
    return m_cmd[d][m_dw[d] - 1 - sh];
  endfunction

  task automatic model_step(input int d, input logic rstn, input logic wrt,
                            input logic [31:0] cmd, input logic [1:0] mode,
                            input logic ss, input logic sclk, input logic mosi,
                            input logic busy, input logic done, input logic [31:0] rd);
    int          lat;
    logic [31:0] mask;
    string       p;
    lat  = 1 + m_fp[d] + 2 * m_dw[d] * m_h[d] + m_bp[d];
    mask = (32'd1 << m_dw[d]) - 32'd1;
    p    = (d == 0) ? "A" : "B";
    if (!rstn) begin
      m_act[d]  = 1'b0;
      m_mode[d] = 2'b00;
      m_rd[d]   = mask;
      chk({p, " rst SS_n"}, 32'(ss), 32'd1);
      chk({p, " rst SCLK"}, 32'(sclk), 32'd0);
      chk({p, " rst busy"}, 32'(busy), 32'd0);
      chk({p, " rst rd_data"}, rd, mask);
      return;
    end
    if (m_act[d]) begin
      m_k[d]++;
      if (m_k[d] < lat) begin
        chk({p, " frame SS_n"}, 32'(ss), 32'd0);
        chk({p, " frame busy"}, 32'(busy), 32'd1);
        chk({p, " frame done"}, 32'(done), 32'd0);
        chk({p, " frame SCLK"}, 32'(sclk), 32'(m_mode[d][1] ^ edges_done(d, m_k[d]) % 2));
        chk({p, " frame MOSI"}, 32'(mosi), 32'(exp_mosi(d, m_k[d])));
      end else begin
        chk({p, " done pulse"}, 32'(done), 32'd1);
        chk({p, " done SS_n"}, 32'(ss), 32'd1);
        chk({p, " done busy"}, 32'(busy), 32'd0);
        chk({p, " done rd_data"}, rd, m_rx[d]);
        chk({p, " done SCLK"}, 32'(sclk), 32'(m_mode[d][1]));
        m_rd[d]  = m_rx[d];
        m_act[d] = 1'b0;
      end
    end else begin
      chk({p, " idle SS_n"}, 32'(ss), 32'd1);
      chk({p, " idle busy"}, 32'(busy), 32'd0);
      chk({p, " idle done"}, 32'(done), 32'd0);
      chk({p, " idle SCLK"}, 32'(sclk), 32'(m_mode[d][1]));
      chk({p, " idle rd_data"}, rd, m_rd[d]);
    end
    if (!m_act[d] && wrt) begin
      m_act[d]  = 1'b1;
      m_k[d]    = 0;
      m_cmd[d]  = cmd & mask;
      m_mode[d] = mode;
      m_rx[d]   = (d == 0 && !lb_a) ? 32'(slv_word) : (cmd & mask);
    end
  endtask

  always @(negedge clk) begin
    model_step(0, rst_a, ifa.wrt, 32'(ifa.cmd), ifa.mode, ifa.SS_n, ifa.SCLK, ifa.MOSI,
               ifa.busy, ifa.done, 32'(ifa.rd_data));
    model_step(1, rst_b, ifb.wrt, 32'(ifb.cmd), ifb.mode, ifb.SS_n, ifb.SCLK, ifb.MOSI,
               ifb.busy, ifb.done, 32'(ifb.rd_data));
  end

  task automatic start_a(input logic [15:0] c, input logic [1:0] m, output int t0);
    @(posedge clk); #1;
    ifa.wrt  = 1'b1;
    ifa.cmd  = c;
    ifa.mode = m;
    t0 = cyc;
  endtask

  // waits for done on DUT d; optionally re-pulses wrt on A at a given cycle offset
  task automatic wait_done(input int d, input int t0, input int repulse, output int lat);
    int n;
    n   = 0;
    lat = -1;
    while (n < 3000 && lat < 0) begin
      @(posedge clk); #1;
      n++;
      if (d == 0) begin
        if (repulse > 0 && cyc - t0 == repulse) begin
          ifa.wrt = 1'b1;
          ifa.cmd = 16'hFFFF;
        end else begin
          ifa.wrt = 1'b0;
        end
        if (ifa.done) lat = cyc - t0;
      end else begin
        ifb.wrt = 1'b0;
        if (ifb.done) lat = cyc - t0;
      end
    end
    if (lat < 0) chk("done timeout", 32'd0, 32'd1);
  endtask

  int t0;
  int lat;

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_act[d]  = 1'b0;
      m_k[d]    = 0;
      m_cmd[d]  = 32'd0;
      m_mode[d] = 2'b00;
      m_rx[d]   = 32'd0;
      m_rd[d]   = (32'd1 << m_dw[d]) - 32'd1;
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    ifa.wrt = 1'b0; ifa.cmd = 16'h0000; ifa.mode = 2'b00;
    ifb.wrt = 1'b0; ifb.cmd = 8'h00;    ifb.mode = 2'b00;

    repeat (3) @(posedge clk);
    #1;
    chk("reset SS_n", 32'(ifa.SS_n), 32'd1);
    chk("reset SCLK", 32'(ifa.SCLK), 32'd0);
    chk("reset MOSI", 32'(ifa.MOSI), 32'd0);
    chk("reset busy", 32'(ifa.busy), 32'd0);
    chk("reset done", 32'(ifa.done), 32'd0);
    chk("reset rd_data", 32'(ifa.rd_data), 32'h0000FFFF);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(posedge clk);

    // mode 00 loopback
    lb_a = 1'b1;
    rises_a = 0;
    start_a(16'hA5C3, 2'b00, t0);
    wait_done(0, t0, 0, lat);
    chk("m00 latency", 32'(lat), 32'd523);
    chk("m00 rd_data", 32'(ifa.rd_data), 32'h0000A5C3);
    chk("m00 rising edges", 32'(rises_a), 32'd16);
    repeat (3) @(posedge clk); #1;
    chk("m00 SCLK idle", 32'(ifa.SCLK), 32'd0);

    // modes 11, 01, 10 against the slave model
    lb_a = 1'b0;
    slv_cpol = 1'b1; slv_cpha = 1'b1;
    start_a(16'h1234, 2'b11, t0);
    wait_done(0, t0, 0, lat);
    chk("m11 rd_data", 32'(ifa.rd_data), 32'h00003C5A);
    chk("m11 slave rx", 32'(slv_rx), 32'h00001234);
    repeat (3) @(posedge clk); #1;
    chk("m11 SCLK idle", 32'(ifa.SCLK), 32'd1);

    slv_cpol = 1'b0; slv_cpha = 1'b1;
    start_a(16'hBEEF, 2'b01, t0);
    wait_done(0, t0, 0, lat);
    chk("m01 rd_data", 32'(ifa.rd_data), 32'h00003C5A);
    chk("m01 slave rx", 32'(slv_rx), 32'h0000BEEF);

    slv_cpol = 1'b1; slv_cpha = 1'b0;
    start_a(16'h0F1E, 2'b10, t0);
    wait_done(0, t0, 0, lat);
    chk("m10 rd_data", 32'(ifa.rd_data), 32'h00003C5A);
    chk("m10 slave rx", 32'(slv_rx), 32'h00000F1E);
    chk("m10 latency", 32'(lat), 32'd523);

    // wrt while busy is ignored
    slv_cpol = 1'b0; slv_cpha = 1'b0;
    repeat (2) @(posedge clk);
    ndone_a = 0;
    start_a(16'h0001, 2'b00, t0);
    wait_done(0, t0, 100, lat);
    repeat (10) @(posedge clk); #1;
    chk("ignore slave rx", 32'(slv_rx), 32'h00000001);
    chk("ignore done count", 32'(ndone_a), 32'd1);
    chk("ignore latency", 32'(lat), 32'd523);

    // asynchronous reset mid-frame, then a clean frame
    lb_a = 1'b1;
    start_a(16'h5A5A, 2'b11, t0);
    while (cyc - t0 < 200) begin
      @(posedge clk); #1;
      ifa.wrt = 1'b0;
    end
    rst_a = 1'b0;
    #1;
    chk("midrst SS_n", 32'(ifa.SS_n), 32'd1);
    chk("midrst SCLK", 32'(ifa.SCLK), 32'd0);
    chk("midrst busy", 32'(ifa.busy), 32'd0);
    chk("midrst rd_data", 32'(ifa.rd_data), 32'h0000FFFF);
    repeat (2) @(posedge clk); #1;
    rst_a = 1'b1;
    start_a(16'h0F0F, 2'b00, t0);
    wait_done(0, t0, 0, lat);
    chk("post-rst rd_data", 32'(ifa.rd_data), 32'h00000F0F);
    chk("post-rst latency", 32'(lat), 32'd523);

    // fast variant: back-to-back frames, wrt in the done cycle
    @(posedge clk); #1;
    ifb.wrt = 1'b1; ifb.cmd = 8'h96; ifb.mode = 2'b00;
    t0 = cyc;
    wait_done(1, t0, 0, lat);
    chk("B first latency", 32'(lat), 32'd35);
    chk("B first rd_data", 32'(ifb.rd_data), 32'h00000096);
    chk("B done-cycle SS_n", 32'(ifb.SS_n), 32'd1);
    ifb.wrt = 1'b1; ifb.cmd = 8'h69;
    t0 = cyc;
    @(posedge clk); #1;
    ifb.wrt = 1'b0;
    chk("B SS_n low again", 32'(ifb.SS_n), 32'd0);
    wait_done(1, t0, 0, lat);
    chk("B second latency", 32'(lat), 32'd35);
    chk("B second rd_data", 32'(ifb.rd_data), 32'h00000069);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
